// File: rtl/univ_shift_reg_burst.sv
// Universal N-bit shift register with eight single-cycle ops and a burst sequencer
// that repeats one shift/rotate op for a programmed count, reporting busy/done.
//
// state | meaning
// IDLE  | i_ctrl executes every edge; a valid start latches op/count instead
// BURST | latched op applied every edge until count runs out

module univ_shift_reg_burst #(
  parameter int N     = 8,
  parameter int CNT_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [2:0]       i_ctrl,
  input  logic [N-1:0]     i_d,
  input  logic             i_sin_l,
  input  logic             i_sin_r,
  input  logic [CNT_W-1:0] i_burst_len,
  input  logic             i_start,
  output logic [N-1:0]     o_q,
  output logic             o_sout_r,
  output logic             o_sout_l,
  output logic             o_busy,
  output logic             o_done
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_SHR  = 3'b001;
  localparam logic [2:0] OP_SHL  = 3'b010;
  localparam logic [2:0] OP_LOAD = 3'b011;
  localparam logic [2:0] OP_ROR  = 3'b100;
  localparam logic [2:0] OP_ROL  = 3'b101;
  localparam logic [2:0] OP_ASR  = 3'b110;
  localparam logic [2:0] OP_CLR  = 3'b111;

  typedef enum logic {IDLE = 1'b0, BURST = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [2:0]       r_op;
  logic [CNT_W-1:0] r_count;
  logic [N-1:0]     r_q;
  logic             r_done;

  logic             w_burst_op;
  logic             w_trigger;
  logic             w_last;
  logic [2:0]       w_op_sel;
  logic [N-1:0]     w_q_next;

  // Only shift/rotate ops are worth repeating; load/clear/hold bursts are meaningless.
  assign w_burst_op = (i_ctrl == OP_SHR) || (i_ctrl == OP_SHL) || (i_ctrl == OP_ROR) ||
                      (i_ctrl == OP_ROL) || (i_ctrl == OP_ASR);
  assign w_trigger  = (r_state == IDLE) && i_start && w_burst_op && (i_burst_len != '0);
  assign w_last     = (r_state == BURST) && (r_count == CNT_W'(1));

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= IDLE;
      r_op    <= OP_HOLD;
      r_count <= '0;
      r_q     <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_last;
      if (w_trigger) begin
        r_op    <= i_ctrl;
        r_count <= i_burst_len;
      end else begin
        r_q <= w_q_next;
        if (r_state == BURST) begin
          r_count <= r_count - CNT_W'(1);
        end
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      IDLE:  if (w_trigger) w_state_next = BURST;
      BURST: if (w_last)    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_op_sel = (r_state == BURST) ? r_op : i_ctrl;
    w_q_next = r_q;
    unique case (w_op_sel)
      OP_HOLD: w_q_next = r_q;
      OP_SHR:  w_q_next = {i_sin_l, r_q[N-1:1]};
      OP_SHL:  w_q_next = {r_q[N-2:0], i_sin_r};
      OP_LOAD: w_q_next = i_d;
      OP_ROR:  w_q_next = {r_q[0], r_q[N-1:1]};
      OP_ROL:  w_q_next = {r_q[N-2:0], r_q[N-1]};
      OP_ASR:  w_q_next = {r_q[N-1], r_q[N-1:1]};
      OP_CLR:  w_q_next = '0;
      default: w_q_next = r_q;
    endcase
  end

  assign o_q      = r_q;
  assign o_sout_r = r_q[0];
  assign o_sout_l = r_q[N-1];
  assign o_busy   = (r_state == BURST);
  assign o_done   = r_done;

endmodule

// File: tb/tb_univ_shift_reg_burst.sv
// Bench for univ_shift_reg_burst (N=4): directed vector table, a bounded long-burst
// sequence, and randomized traffic checked against a behavioural model.

module tb_univ_shift_reg_burst;

  localparam int N     = 4;
  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [2:0]       ctrl;
  logic [N-1:0]     d;
  logic             sin_l;
  logic             sin_r;
  logic [CNT_W-1:0] burst_len;
  logic             start;
  logic [N-1:0]     q;
  logic             sout_r;
  logic             sout_l;
  logic             busy;
  logic             done;

  int n_cmp = 0;
  int n_bad = 0;

  univ_shift_reg_burst #(.N(N), .CNT_W(CNT_W)) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_ctrl      (ctrl),
    .i_d         (d),
    .i_sin_l     (sin_l),
    .i_sin_r     (sin_r),
    .i_burst_len (burst_len),
    .i_start     (start),
    .o_q         (q),
    .o_sout_r    (sout_r),
    .o_sout_l    (sout_l),
    .o_busy      (busy),
    .o_done      (done)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic [2:0] ctrl;
    logic [3:0] d;
    logic       sin_l;
    logic       sin_r;
    logic [3:0] len;
    logic       start;
    logic [3:0] exp_q;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(logic r, logic [2:0] c, logic [3:0] dd, logic sl, logic sr,
                              logic [3:0] l, logic s, logic [3:0] eq, logic eb, logic ed);
    vec_t v;
    v.rst = r; v.ctrl = c; v.d = dd; v.sin_l = sl; v.sin_r = sr; v.len = l; v.start = s;
    v.exp_q = eq; v.exp_busy = eb; v.exp_done = ed;
    return v;
  endfunction

  task automatic check(string name, int act, int exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic check_all(string tag, logic [3:0] eq, logic eb, logic ed);
    check({tag, ".q"},      int'(q),      int'(eq));
    check({tag, ".sout_r"}, int'(sout_r), int'(eq[0]));
    check({tag, ".sout_l"}, int'(sout_l), int'(eq[N-1]));
    check({tag, ".busy"},   int'(busy),   int'(eb));
    check({tag, ".done"},   int'(done),   int'(ed));
  endtask

  task automatic drive(logic r, logic [2:0] c, logic [3:0] dd, logic sl, logic sr,
                       logic [3:0] l, logic s);
    rst = r; ctrl = c; d = dd; sin_l = sl; sin_r = sr; burst_len = l; start = s;
  endtask

  // Reference behaviour of one op, written as plain arithmetic on an integer value.
  function automatic int ref_op(int op, int qv, int sl, int sr);
    int mask = (1 << N) - 1;
    int msb  = 1 << (N - 1);
    case (op)
      1: return (qv >> 1) + sl * msb;
      2: return ((qv * 2) + sr) & mask;
      4: return (qv >> 1) + (qv % 2) * msb;
      5: return ((qv * 2) & mask) + ((qv >= msb) ? 1 : 0);
      6: return (qv >> 1) + (qv & msb);
      7: return 0;
      default: return qv;
    endcase
  endfunction

  int m_q, m_rem, m_op, m_done;

  initial begin
    drive(1'b1, 3'b011, 4'hF, 1'b0, 1'b0, 4'd0, 1'b0);

    vecs.push_back(mk(1, 3'b011, 4'hF, 0, 0, 4'd0,  0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 3'b011, 4'h6, 0, 0, 4'd0,  0, 4'h6, 0, 0));
    vecs.push_back(mk(0, 3'b001, 4'h0, 1, 0, 4'd0,  0, 4'hB, 0, 0));
    vecs.push_back(mk(0, 3'b010, 4'h0, 0, 0, 4'd0,  0, 4'h6, 0, 0));
    vecs.push_back(mk(0, 3'b000, 4'h0, 1, 1, 4'd0,  0, 4'h6, 0, 0));
    vecs.push_back(mk(0, 3'b000, 4'h0, 1, 1, 4'd0,  0, 4'h6, 0, 0));
    vecs.push_back(mk(0, 3'b011, 4'h9, 0, 0, 4'd0,  0, 4'h9, 0, 0));
    vecs.push_back(mk(0, 3'b100, 4'h0, 0, 0, 4'd0,  0, 4'hC, 0, 0));
    vecs.push_back(mk(0, 3'b101, 4'h0, 0, 0, 4'd0,  0, 4'h9, 0, 0));
    vecs.push_back(mk(0, 3'b110, 4'h0, 0, 0, 4'd0,  0, 4'hC, 0, 0));
    vecs.push_back(mk(0, 3'b110, 4'h0, 0, 0, 4'd0,  0, 4'hE, 0, 0));
    vecs.push_back(mk(0, 3'b011, 4'h1, 0, 0, 4'd0,  0, 4'h1, 0, 0));
    // ROL burst of 3 with CLR on ctrl while busy
    vecs.push_back(mk(0, 3'b101, 4'h0, 0, 0, 4'd3,  1, 4'h1, 1, 0));
    vecs.push_back(mk(0, 3'b111, 4'h0, 0, 0, 4'd0,  0, 4'h2, 1, 0));
    vecs.push_back(mk(0, 3'b111, 4'h0, 0, 0, 4'd0,  1, 4'h4, 1, 0));
    vecs.push_back(mk(0, 3'b111, 4'h0, 0, 0, 4'd0,  0, 4'h8, 0, 1));
    vecs.push_back(mk(0, 3'b001, 4'h0, 0, 0, 4'd0,  0, 4'h4, 0, 0));
    vecs.push_back(mk(0, 3'b011, 4'hF, 0, 0, 4'd0,  0, 4'hF, 0, 0));
    // SHR burst of 10 aborted by reset
    vecs.push_back(mk(0, 3'b001, 4'h0, 0, 0, 4'd10, 1, 4'hF, 1, 0));
    vecs.push_back(mk(0, 3'b001, 4'h0, 0, 0, 4'd0,  0, 4'h7, 1, 0));
    vecs.push_back(mk(0, 3'b001, 4'h0, 0, 0, 4'd0,  0, 4'h3, 1, 0));
    vecs.push_back(mk(1, 3'b001, 4'h0, 0, 0, 4'd0,  0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 4'd0,  0, 4'h0, 0, 0));
    vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 4'd0,  0, 4'h0, 0, 0));
    // start ignored for LOAD and for a zero length
    vecs.push_back(mk(0, 3'b011, 4'h5, 0, 0, 4'd5,  1, 4'h5, 0, 0));
    vecs.push_back(mk(0, 3'b001, 4'h0, 0, 0, 4'd0,  1, 4'h2, 0, 0));
    vecs.push_back(mk(0, 3'b000, 4'h0, 0, 0, 4'd0,  0, 4'h2, 0, 0));

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ctrl, vecs[i].d, vecs[i].sin_l, vecs[i].sin_r,
            vecs[i].len, vecs[i].start);
      @(posedge clk);
      #1;
      check_all($sformatf("vec%0d", i), vecs[i].exp_q, vecs[i].exp_busy, vecs[i].exp_done);
    end

    // Maximum-length SHL burst with live sin_r=1: busy must last exactly 15 cycles.
    begin
      int busy_cycles = 0;
      int waited = 0;
      bit seen_done = 0;
      drive(0, 3'b011, 4'h0, 0, 0, 4'd0, 0);
      @(posedge clk); #1;
      drive(0, 3'b010, 4'h0, 0, 1, 4'd15, 1);
      @(posedge clk); #1;
      drive(0, 3'b000, 4'h0, 0, 1, 4'd0, 0);
      while (!seen_done && waited < 30) begin
        if (busy) busy_cycles++;
        @(posedge clk); #1;
        waited++;
        if (done) seen_done = 1;
      end
      check("long.done_seen", int'(seen_done), 1);
      check("long.busy_cycles", busy_cycles, 15);
      check("long.q", int'(q), 4'hF);
      @(posedge clk); #1;
      check("long.done_clears", int'(done), 0);
    end

    // Randomized traffic against the behavioural model.
    drive(1, 3'b000, 4'h0, 0, 0, 4'd0, 0);
    @(posedge clk); #1;
    m_q = 0; m_rem = 0; m_op = 0; m_done = 0;
    for (int cyc = 0; cyc < 600; cyc++) begin
      drive(($urandom_range(0, 59) == 0), 3'($urandom_range(0, 7)), 4'($urandom),
            1'($urandom), 1'($urandom), 4'($urandom_range(0, 6)),
            ($urandom_range(0, 3) == 0));
      if (rst) begin
        m_q = 0; m_rem = 0; m_done = 0;
      end else if (m_rem > 0) begin
        m_q = ref_op(m_op, m_q, sin_l, sin_r);
        m_rem--;
        m_done = (m_rem == 0);
      end else begin
        m_done = 0;
        if (start && ctrl inside {3'b001, 3'b010, 3'b100, 3'b101, 3'b110} && burst_len != 0) begin
          m_op  = ctrl;
          m_rem = burst_len;
        end else if (ctrl == 3'b011) begin
          m_q = d;
        end else begin
          m_q = ref_op(ctrl, m_q, sin_l, sin_r);
        end
      end
      @(posedge clk); #1;
      check_all($sformatf("rnd%0d", cyc), 4'(m_q), (m_rem > 0), 1'(m_done));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
